// File: rtl/hazard_unit_cfg_if.sv
// hazard_unit_cfg_if: signal bundle between the 5-stage pipeline and its hazard unit
// Ports: master = pipeline (drives i_* operands/status, reads o_* controls),
//        slave  = hazard unit (reads i_*, drives stall/flush/forward selects and the stall counter)
interface hazard_unit_cfg_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [6:0]       i_opcode_if, i_opcode_ex;
    logic [REG_W-1:0] i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e;
    logic [REG_W-1:0] i_ex_rd, i_mem_rd, i_wb_rd;
    logic             i_ex_regwrite, i_mem_regwrite, i_wb_regwrite;
    logic             i_ex_is_load, i_pc_sel_ex, i_mem_busy;
    logic             o_stall_f, o_stall_d, o_stall_e, o_stall_m;
    logic             o_flush_d, o_flush_e, o_flush_m;
    logic [1:0]       o_fwd_a, o_fwd_b;
    logic [CNT_W-1:0] o_stall_cnt;
    modport master (
        output i_opcode_if, i_opcode_ex, i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e,
               i_ex_rd, i_mem_rd, i_wb_rd, i_ex_regwrite, i_mem_regwrite, i_wb_regwrite,
               i_ex_is_load, i_pc_sel_ex, i_mem_busy,
        input  o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d, o_flush_e, o_flush_m,
               o_fwd_a, o_fwd_b, o_stall_cnt
    );
    modport slave (
        input  i_opcode_if, i_opcode_ex, i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e,
               i_ex_rd, i_mem_rd, i_wb_rd, i_ex_regwrite, i_mem_regwrite, i_wb_regwrite,
               i_ex_is_load, i_pc_sel_ex, i_mem_busy,
        output o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d, o_flush_e, o_flush_m,
               o_fwd_a, o_fwd_b, o_stall_cnt
    );
endinterface

// File: rtl/hazard_unit_cfg.sv
// hazard_unit_cfg: configurable forwarding, load-use/branch/memory stall and flush control for a 5-stage RV32I core
// Ports: i_clk, i_reset_n (async active-low); hz = slave side of hazard_unit_cfg_if
//        (pipeline register/opcode status in, stall/flush/forward selects and stall-cycle count out)
module hazard_unit_cfg #(
    parameter int REG_W     = 5,
    parameter int LOAD_LAT  = 1,
    parameter int BR_MODE   = 0,
    parameter int BR_SHADOW = 3,
    parameter int CNT_W     = 32
) (
    input logic               i_clk,
    input logic               i_reset_n,
    hazard_unit_cfg_if.slave  hz
);
    typedef enum logic [1:0] {IDLE, LD_WAIT, BR_WAIT} state_t;
    localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] BR_INIT = 3'(BR_SHADOW - 1);
    state_t           state, state_nx;
    logic [2:0]       cnt, cnt_nx;
    logic [CNT_W-1:0] stall_cnt;
    logic             ct_if, ct_ex, lu, taken, br_go;
    logic             sf, sd, se, sm, fd, fe, fm;
    assign ct_if = hz.i_opcode_if == 7'b1100011 || hz.i_opcode_if == 7'b1101111 || hz.i_opcode_if == 7'b1100111;
    assign ct_ex = hz.i_opcode_ex == 7'b1100011 || hz.i_opcode_ex == 7'b1101111 || hz.i_opcode_ex == 7'b1100111;
    assign lu    = hz.i_ex_is_load && hz.i_ex_regwrite && hz.i_ex_rd != '0 &&
                   (hz.i_ex_rd == hz.i_rs1_d || hz.i_ex_rd == hz.i_rs2_d);
    assign taken = BR_MODE == 1 && hz.i_pc_sel_ex;
    // a transfer already in EX means the one in IF is its own shadow: no second stall
    assign br_go = BR_MODE == 0 && ct_if && !ct_ex;
    assign hz.o_fwd_a = hz.i_rs1_e == '0 ? 2'b00 :
                        hz.i_mem_regwrite && hz.i_mem_rd == hz.i_rs1_e ? 2'b10 :
                        hz.i_wb_regwrite && hz.i_wb_rd == hz.i_rs1_e ? 2'b01 : 2'b00;
    assign hz.o_fwd_b = hz.i_rs2_e == '0 ? 2'b00 :
                        hz.i_mem_regwrite && hz.i_mem_rd == hz.i_rs2_e ? 2'b10 :
                        hz.i_wb_regwrite && hz.i_wb_rd == hz.i_rs2_e ? 2'b01 : 2'b00;
    always_comb begin
        {sf, sd, se, sm, fd, fe, fm} = '0;
        state_nx = state;
        cnt_nx = cnt;
        if (hz.i_mem_busy) begin
            {sf, sd, se, sm} = '1;
        end else if (taken) begin
            {fd, fe} = '1;
            state_nx = IDLE;
            cnt_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lu) begin
                        {sf, sd, fe} = '1;
                        state_nx = LOAD_LAT > 1 ? LD_WAIT : IDLE;
                        cnt_nx = LD_INIT;
                    end else if (br_go) begin
                        sf = 1'b1;
                        state_nx = BR_WAIT;
                        cnt_nx = BR_INIT;
                    end
                end
                // the detection cycle is the first of LOAD_LAT stalls, so leave when the count hits 1
                LD_WAIT: begin
                    {sf, sd, fe} = '1;
                    cnt_nx = cnt - 3'd1;
                    state_nx = cnt <= 3'd1 ? IDLE : LD_WAIT;
                end
                BR_WAIT: begin
                    sf = cnt != '0;
                    {fd, fe, fm} = {3{cnt == '0}};
                    cnt_nx = cnt != '0 ? cnt - 3'd1 : cnt;
                    state_nx = cnt != '0 ? BR_WAIT : IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (sf && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
    // controls are forced low while reset is held, independent of the clock
    assign hz.o_stall_f   = sf & i_reset_n;
    assign hz.o_stall_d   = sd & i_reset_n;
    assign hz.o_stall_e   = se & i_reset_n;
    assign hz.o_stall_m   = sm & i_reset_n;
    assign hz.o_flush_d   = fd & i_reset_n;
    assign hz.o_flush_e   = fe & i_reset_n;
    assign hz.o_flush_m   = fm & i_reset_n;
    assign hz.o_stall_cnt = stall_cnt;
endmodule

// File: tb/tb_hazard_unit_cfg.sv
// tb_hazard_unit_cfg: directed checks of a stall-fetch unit (u0) and a predict-not-taken unit with 4-bit counter (u1)
module tb_hazard_unit_cfg;
    localparam logic [6:0] NOP = 7'b0010011, LOAD = 7'b0000011, BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    logic i_clk, rst_n;
    int   n_checks = 0, n_fail = 0;
    hazard_unit_cfg_if #(.REG_W(5), .CNT_W(32)) if0 ();
    hazard_unit_cfg_if #(.REG_W(5), .CNT_W(4))  if1 ();
    hazard_unit_cfg #(.LOAD_LAT(3), .BR_MODE(0), .BR_SHADOW(3), .CNT_W(32)) u0 (.i_clk(i_clk), .i_reset_n(rst_n), .hz(if0));
    hazard_unit_cfg #(.LOAD_LAT(3), .BR_MODE(1), .BR_SHADOW(3), .CNT_W(4))  u1 (.i_clk(i_clk), .i_reset_n(rst_n), .hz(if1));
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always_comb begin
        if1.i_opcode_if    = if0.i_opcode_if;
        if1.i_opcode_ex    = if0.i_opcode_ex;
        if1.i_rs1_d        = if0.i_rs1_d;
        if1.i_rs2_d        = if0.i_rs2_d;
        if1.i_rs1_e        = if0.i_rs1_e;
        if1.i_rs2_e        = if0.i_rs2_e;
        if1.i_ex_rd        = if0.i_ex_rd;
        if1.i_mem_rd       = if0.i_mem_rd;
        if1.i_wb_rd        = if0.i_wb_rd;
        if1.i_ex_regwrite  = if0.i_ex_regwrite;
        if1.i_mem_regwrite = if0.i_mem_regwrite;
        if1.i_wb_regwrite  = if0.i_wb_regwrite;
        if1.i_ex_is_load   = if0.i_ex_is_load;
        if1.i_pc_sel_ex    = if0.i_pc_sel_ex;
        if1.i_mem_busy     = if0.i_mem_busy;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask
    task automatic idle();
        if0.i_opcode_if = NOP; if0.i_opcode_ex = NOP;
        if0.i_rs1_d = '0; if0.i_rs2_d = '0; if0.i_rs1_e = '0; if0.i_rs2_e = '0;
        if0.i_ex_rd = '0; if0.i_mem_rd = '0; if0.i_wb_rd = '0;
        if0.i_ex_regwrite = 0; if0.i_mem_regwrite = 0; if0.i_wb_regwrite = 0;
        if0.i_ex_is_load = 0; if0.i_pc_sel_ex = 0; if0.i_mem_busy = 0;
    endtask
    task automatic load_use();
        if0.i_opcode_ex = LOAD; if0.i_ex_is_load = 1; if0.i_ex_regwrite = 1;
        if0.i_ex_rd = 5'd7; if0.i_rs2_d = 5'd7;
    endtask
    initial begin
        rst_n = 0;
        idle();
        if0.i_mem_busy = 1;
        #2;
        check("rst_stalls", {if0.o_stall_f, if0.o_stall_d, if0.o_stall_e, if0.o_stall_m}, 4'b0000);
        check("rst_cnt", if0.o_stall_cnt, 0);
        if0.i_mem_busy = 0;
        @(negedge i_clk);
        rst_n = 1;
        tick();
        if0.i_rs1_e = 5'd5; if0.i_mem_rd = 5'd5; if0.i_wb_rd = 5'd5;
        if0.i_mem_regwrite = 1; if0.i_wb_regwrite = 1; if0.i_rs2_e = 5'd9;
        #1;
        check("fwd_a_mem", if0.o_fwd_a, 2'b10);
        check("fwd_b_none", if0.o_fwd_b, 2'b00);
        if0.i_rs2_e = 5'd5;
        #1;
        check("fwd_b_mem", if0.o_fwd_b, 2'b10);
        if0.i_mem_regwrite = 0;
        #1;
        check("fwd_a_wb", if0.o_fwd_a, 2'b01);
        if0.i_rs1_e = 5'd0;
        #1;
        check("fwd_a_x0", if0.o_fwd_a, 2'b00);
        check("fwd_b_wb", if0.o_fwd_b, 2'b01);
        tick();
        idle();
        load_use();
        #1;
        check("lu_c0", {if0.o_stall_f, if0.o_stall_d, if0.o_flush_e}, 3'b111);
        tick();
        idle();
        for (int i = 1; i < 3; i++) begin
            #1;
            check($sformatf("lu_c%0d", i), {if0.o_stall_f, if0.o_stall_d, if0.o_flush_e}, 3'b111);
            tick();
        end
        #1;
        check("lu_done", {if0.o_stall_f, if0.o_stall_d, if0.o_flush_e}, 3'b000);
        check("lu_cnt", if0.o_stall_cnt, 3);
        tick();
        if0.i_opcode_if = BEQ;
        #1;
        check("br_c0", {if0.o_stall_f, if0.o_flush_d}, 2'b10);
        check("br_m1_nostall", if1.o_stall_f, 0);
        tick();
        idle();
        for (int i = 1; i < 3; i++) begin
            #1;
            check($sformatf("br_c%0d", i), {if0.o_stall_f, if0.o_flush_d, if0.o_flush_e, if0.o_flush_m}, 4'b1000);
            tick();
        end
        #1;
        check("br_flush", {if0.o_stall_f, if0.o_flush_d, if0.o_flush_e, if0.o_flush_m}, 4'b0111);
        tick();
        #1;
        check("br_after", {if0.o_stall_f, if0.o_flush_d, if0.o_flush_e, if0.o_flush_m}, 4'b0000);
        check("br_cnt", if0.o_stall_cnt, 6);
        if0.i_opcode_if = BEQ; if0.i_opcode_ex = JAL;
        #1;
        check("br_ct_in_ex", if0.o_stall_f, 0);
        tick();
        idle();
        if0.i_opcode_if = JALR;
        #1;
        check("bz_c0", if0.o_stall_f, 1);
        tick();
        idle();
        #1;
        check("bz_c1", if0.o_stall_f, 1);
        tick();
        if0.i_mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bz_busy%0d", i), {if0.o_stall_f, if0.o_stall_d, if0.o_stall_e, if0.o_stall_m,
                  if0.o_flush_d, if0.o_flush_e, if0.o_flush_m}, 7'b1111000);
            tick();
        end
        if0.i_mem_busy = 0;
        #1;
        check("bz_resume", {if0.o_stall_f, if0.o_flush_d}, 2'b10);
        tick();
        #1;
        check("bz_flush", {if0.o_stall_f, if0.o_flush_d, if0.o_flush_e, if0.o_flush_m}, 4'b0111);
        tick();
        #1;
        check("bz_cnt", if0.o_stall_cnt, 13);
        load_use();
        #1;
        check("m1_c0", {if1.o_stall_f, if1.o_flush_e}, 2'b11);
        tick();
        idle();
        if0.i_pc_sel_ex = 1;
        #1;
        check("m1_taken_flush", {if1.o_flush_d, if1.o_flush_e, if1.o_flush_m}, 3'b110);
        check("m0_sel_ignored", {if0.o_stall_f, if0.o_flush_d}, 2'b10);
        tick();
        if0.i_pc_sel_ex = 0;
        #1;
        check("m1_stall_drop", {if1.o_stall_f, if1.o_flush_e}, 2'b00);
        check("m0_still_wait", if0.o_stall_f, 1);
        tick();
        #1;
        check("m0_done", if0.o_stall_f, 0);
        tick();
        load_use();
        tick();
        idle();
        #1;
        check("rst_pre", {if0.o_stall_f, if0.o_stall_d, if0.o_flush_e}, 3'b111);
        check("rst_pre_cnt", if0.o_stall_cnt, 17);
        #1;
        rst_n = 0;
        #1;
        check("rst_async", {if0.o_stall_f, if0.o_stall_d, if0.o_flush_e}, 3'b000);
        check("rst_async_cnt", if0.o_stall_cnt, 0);
        #2;
        rst_n = 1;
        tick();
        #1;
        check("rst_aborted", if0.o_stall_f, 0);
        check("rst_cnt_hold", if0.o_stall_cnt, 0);
        if0.i_mem_busy = 1;
        repeat (20) tick();
        if0.i_mem_busy = 0;
        #1;
        check("sat_cnt4", if1.o_stall_cnt, 15);
        check("cnt32", if0.o_stall_cnt, 20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
